uart_tx_arbiter: RTL

- Shares one uart_tx byte port (wreq/wgnt/wdata handshake) between N_REQ requesters, using round-robin arbitration.
- Supports message locking: once a requester wins, it keeps the UART until it sends a byte flagged last. Multi-byte messages are therefore never interleaved.
- Sits between application byte sources (sensor dumps, debug printers) and a single uart_tx instance on the board top.

---
 rtl/uart_tx_arb_pkg.sv | 22 ++
 rtl/uart_tx_arb_rr.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_pkg
//   Shared definitions for the uart_tx byte-port arbiter:
//     - arb_state_e : arbiter FSM states (ARB_IDLE, ARB_LOCK)
//     - UART_BYTE_W : width of one UART byte lane
//     - wrap_inc()  : modulo-n increment used to advance the round-robin pointer
// -----------------------------------------------------------------------------
package uart_tx_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,  // free: rotating-priority arbitration every cycle
    ARB_LOCK = 1'b1   // reserved for one requester until its last byte
  } arb_state_e;

  // Next index after idx in a ring of n slots (n-1 wraps to 0).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_rr
//   Purely combinational rotating priority encoder. The requester at rr_ptr has
//   the highest priority, then rr_ptr+1, ... wrapping modulo N_REQ.
//
// Ports:
//   req     in  N_REQ  request vector
//   rr_ptr  in  IDW    index holding highest priority this cycle
//   winner  out IDW    first requesting index at or after rr_ptr (0 if none)
//   any_req out 1      at least one request is present
// -----------------------------------------------------------------------------
module uart_tx_arb_rr #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [IDW-1:0]   winner,
  output logic             any_req
);

  // Requester index that sits at priority position k for a given pointer.
  function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] ptr, input int k);
    int idx;
    idx = int'(ptr) + k;
    if (idx >= N_REQ) idx = idx - N_REQ;
    return IDW'(idx);
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    winner  = '0;
    any_req = |req;
    // Scan from lowest priority to highest so the highest-priority hit is the
    // last write and therefore the one that sticks.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[slot(rr_ptr, k)]) winner = slot(rr_ptr, k);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx byte port between N_REQ requesters with round-robin
//   arbitration and message locking: once a requester gets a non-last byte
//   through, the UART stays reserved for it until it sends a byte flagged last.
//   Requester-to-UART routing is combinational (zero cycle latency); only the
//   state / owner / round-robin pointer are registered.
//
//   Optional feature (compile-time macro UART_TX_ARB_TIMEOUT_EN): a lock whose
//   owner stays silent for TIMEOUT consecutive cycles is force-released and
//   lock_timeout pulses for one cycle. Without the macro there is no counter
//   and no lock_timeout port.
//
// Ports:
//   clk           in   1         system clock
//   rst           in   1         synchronous reset, active-high
//   s_wreq        in   N_REQ     per-requester byte request
//   s_wgnt        out  N_REQ     per-requester grant (accept = s_wreq & s_wgnt)
//   s_wdata       in   8*N_REQ   requester i byte at [8i+7:8i]
//   s_wlast       in   N_REQ     byte is last of its message
//   m_wreq        out  1         request to uart_tx
//   m_wgnt        in   1         grant from uart_tx
//   m_wdata       out  8         byte to uart_tx
//   owner         out  IDW       requester currently routed to uart_tx
//   lock_timeout  out  1         forced-release pulse (macro builds only)
//   busy          out  1         high while the UART is locked to a requester
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 1000000,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             s_wreq,
  output logic [N_REQ-1:0]             s_wgnt,
  input  logic [UART_BYTE_W*N_REQ-1:0] s_wdata,
  input  logic [N_REQ-1:0]             s_wlast,
  output logic                         m_wreq,
  input  logic                         m_wgnt,
  output logic [UART_BYTE_W-1:0]       m_wdata,
  output logic [IDW-1:0]               owner,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic                         lock_timeout,
`endif
  output logic                         busy
);

  arb_state_e     state_q,  state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q,  owner_d;

  logic [IDW-1:0] winner;
  logic           any_req;
  logic [IDW-1:0] sel;      // requester routed to the UART this cycle
  logic           route;    // sel is meaningful (locked, or someone requesting)
  logic           xfer;     // a byte is accepted by uart_tx this cycle
  logic           sel_last;

  uart_tx_arb_rr #(.N_REQ(N_REQ)) u_rr (
    .req     (s_wreq),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // ---------------------------------------------------------------------------
  // Combinational routing between the selected requester and uart_tx.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel      = (state_q == ARB_LOCK) ? owner_q : winner;
    route    = (state_q == ARB_LOCK) || any_req;
    sel_last = s_wlast[sel];
    s_wgnt   = '0;
    m_wreq   = 1'b0;
    m_wdata  = '0;
    if (route) begin
      m_wdata = s_wdata[sel*UART_BYTE_W +: UART_BYTE_W];
      // Handshakes are suppressed during reset so no byte is consumed by a
      // requester while the arbiter state is being cleared.
      if (!rst) begin
        m_wreq      = s_wreq[sel];
        s_wgnt[sel] = m_wgnt;
      end
    end
  end

  assign xfer  = m_wreq && m_wgnt;
  assign owner = sel;
  assign busy  = (state_q == ARB_LOCK);

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             timeout_hit;

  assign lock_timeout = timeout_hit;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          if (sel_last) begin
            // Single-byte message: stay free and rotate priority past winner.
            rr_ptr_d = IDW'(wrap_inc(int'(winner), N_REQ));
          end else begin
            state_d = ARB_LOCK;
            owner_d = winner;
`ifdef UART_TX_ARB_TIMEOUT_EN
            idle_cnt_d = '0;
`endif
          end
        end
      end

      ARB_LOCK: begin
        if (xfer && sel_last) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDW'(wrap_inc(int'(owner_q), N_REQ));
`ifdef UART_TX_ARB_TIMEOUT_EN
          idle_cnt_d = '0;
        end else if (s_wreq[owner_q]) begin
          // Any owner activity proves the message is still alive.
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ARB_IDLE;
          rr_ptr_d    = IDW'(wrap_inc(int'(owner_q), N_REQ));
          idle_cnt_d  = '0;
          timeout_hit = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
`endif
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // rather than listed in the sensitivity list; all state uses non-blocking
    // assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

endmodule
